reg_pipe: RTL and testbench
===========================

# reg_pipe

Parametrised, elastic register pipeline. It carries WIDTH-bit data through DEPTH register stages, and each stage has a valid bit and a clock enable derived from a valid/ready handshake. It is the successor to the single-bit asynchronous-reset D flip-flop. It adds width, depth, backpressure, bubble collapsing, a synchronous flush, a programmable reset value and an occupancy count. It sits between producer and consumer blocks that need a fixed-latency, stallable register path.

## Interface
- WIDTH, 8: data width in bits; WIDTH ≥ 1.
- DEPTH, 4: number of register stages; DEPTH ≥ 1.
- RST_VAL, 0: WIDTH-bit value loaded into every data register on reset.
- clk  input  1  single clock. All state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Takes effect immediately on the falling edge of rst, independent of clk.
- in_valid  input  1  producer has data on in_data.
- in_ready  output  1  stage 0 can accept data this cycle.
- in_data  input  WIDTH  producer data.
- out_valid  output  1  last stage (stage DEPTH-1) holds valid data.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  contents of stage DEPTH-1.
- flush  input  1  synchronous discard of all pipeline contents.
- occupancy  output  $clog2(DEPTH+1)  number of stages with their valid bit set.

## Operation
- State per stage i (0..DEPTH-1): data register d[i] and valid bit v[i].
- Reset (rst=0): all v[i]=0 and all d[i]=RST_VAL. Resulting outputs: out_valid=0, out_data=RST_VAL, occupancy=0, in_ready=1.
- Advance conditions:
  - move[DEPTH-1] = v[DEPTH-1] & out_ready.
  - For i < DEPTH-1: move[i] = v[i] & (!v[i+1] | move[i+1]).
- Stage load conditions:
  - Stage i+1 loads d[i] when move[i].
  - Stage 0 loads in_data when in_valid & in_ready.
- in_ready = !v[0] | move[0]. This is a combinational path from out_ready through the ready chain; it is intentional, and there is no skid buffer.
- Bubble collapsing: a valid stage advances into an empty downstream stage even while out_ready=0. Data therefore packs toward the output.
- Valid update per stage:
  - v[i] is set when stage i is loaded.
  - v[i] is cleared when move[i] occurs and stage i is not loaded in the same cycle.
  - Otherwise v[i] holds.
- Data registers load only on their load condition and otherwise hold. out_data holds its last value when out_valid=0.
- Ordering is strictly FIFO. No item is duplicated or dropped except by flush.
- Flush (synchronous, highest priority after reset):
  - All v[i] clear at the next edge.
  - in_ready is forced to 0 during the flush cycle, and input offered in that cycle is not accepted.
  - move[DEPTH-1] is forced to 0, so no output transfer is counted in that cycle.
  - d[i] are not modified.
- occupancy = popcount(v). It is derived from registers only.

## Timing
- Latency into an empty pipe: an item accepted in cycle c (in_valid & in_ready at the edge ending c) is on out_data with out_valid=1 in cycle c+DEPTH. For DEPTH=1 that is cycle c+1.
- Throughput: 1 item/cycle sustained while out_ready=1.
- Full pipe (all v=1) with out_ready=0: in_ready=0.
- Full pipe with out_ready=1: in_ready=1, so a push and a pop complete in the same cycle and occupancy stays DEPTH.
- Simultaneous flush and push: the push is rejected and the pipe is empty next cycle.
- Reset asserted mid-stream: all state returns to its reset values immediately, without waiting for clk. The first accept is possible on the first rising edge after rst=1.

## Test plan
- Reset: drive rst=0 with in_valid=1 toggling. Expect out_valid=0, out_data=RST_VAL (0x00), occupancy=0, in_ready=1. Release rst and push 0xA5 in cycle c. Expect out_valid=1 with out_data=0xA5 in cycle c+4 (DEPTH=4).
- Streaming: hold out_ready=1 and push 0x01..0x10 on consecutive cycles. Expect in_ready constantly 1, the output sequence 0x01..0x10 in order on consecutive cycles, and steady occupancy 4.
- Backpressure and collapse: hold out_ready=0 and offer 0x11..0x15 back-to-back. Expect 4 accepted, in_ready=0 from the 5th offer, occupancy=4 with out_data=0x11. Then set out_ready=1 and offer 0x15 each cycle. Expect outputs 0x11,0x12,0x13,0x14,0x15 in order and occupancy staying 4 while pushes continue.
- Bubble fill: push one item, then idle with out_ready=0. Expect the item to reach the last stage after 4 cycles, then push 3 more. Expect occupancy 4 and in_ready=0.
- Flush: with occupancy=3 and in_valid=1 carrying 0x77, assert flush for 1 cycle. Expect in_ready=0 in that cycle, occupancy=0 and out_valid=0 next cycle, and 0x77 never appearing at the output.
- Async reset mid-operation: with occupancy=4, pulse rst low between clock edges. Expect occupancy=0, out_valid=0 and out_data=RST_VAL before the next rising edge. Normal operation resumes after release.

Source files
------------

// File: rtl/reg_pipe.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready handshake,
// bubble collapsing, synchronous flush and occupancy count.
module reg_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              OCC_W   = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] ld;
  logic             down_go;

  // Ready ripples from the consumer back to stage 0; a stage may move when
  // the stage below is empty or is itself moving this cycle.
  always_comb begin
    move    = '0;
    down_go = out_ready & ~flush;
    for (int i = DEPTH-1; i >= 0; i--) begin
      move[i] = v[i] & down_go;
      down_go = ~v[i] | move[i];
    end
  end

  assign in_ready = down_go & ~flush;

  // Loads are suppressed during flush so data registers keep their contents.
  always_comb begin
    ld    = '0;
    ld[0] = in_valid & in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      ld[i] = move[i-1] & ~flush;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RST_VAL;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      v <= ld | (v & ~move);
      if (ld[0]) d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (ld[i]) d[i] <= d[i-1];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench for reg_pipe: an item-position queue model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_reg_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] RST_VAL = 8'h00;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             flush = 1'b0;
  logic [OCC_W-1:0] occupancy;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  // Model: oldest item first; each entry records the stage it sits in.
  int               mpos[$];
  logic [WIDTH-1:0] mdat[$];
  logic [WIDTH-1:0] mlast = RST_VAL;

  reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predict this cycle's outputs from the item positions, then advance.
  int               np[$];
  logic [WIDTH-1:0] nd[$];
  int               limit;
  int               p;
  bit               rdy_exp;
  logic [WIDTH-1:0] lo;

  always @(negedge clk) begin
    if (started) begin
      if (!rst) begin
        mpos.delete();
        mdat.delete();
        mlast = RST_VAL;
      end
      np.delete();
      nd.delete();
      limit = DEPTH;
      lo = mlast;
      for (int k = 0; k < mpos.size(); k++) begin
        if (mpos[k] == DEPTH-1 && out_ready && !flush) begin
          limit = DEPTH;
        end else begin
          p = (mpos[k] + 1 < limit) ? mpos[k] + 1 : mpos[k];
          if (p == DEPTH-1 && mpos[k] != DEPTH-1) lo = mdat[k];
          np.push_back(p);
          nd.push_back(mdat[k]);
          limit = p;
        end
      end
      rdy_exp = !flush && (np.size() == 0 || np[np.size()-1] > 0);

      chk("m_out_valid", int'(out_valid), int'(mpos.size() > 0 && mpos[0] == DEPTH-1));
      chk("m_out_data", int'(out_data), int'(mlast));
      chk("m_occupancy", int'(occupancy), mpos.size());
      chk("m_in_ready", int'(in_ready), int'(rdy_exp));

      if (rst) begin
        if (flush) begin
          mpos.delete();
          mdat.delete();
        end else begin
          if (in_valid && rdy_exp) begin
            np.push_back(0);
            nd.push_back(in_data);
            if (DEPTH == 1) lo = in_data;
          end
          mpos = np;
          mdat = nd;
          mlast = lo;
        end
      end
    end
  end

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH+1) tick();
    chk("drain_occ", int'(occupancy), 0);
  endtask

  initial begin
    #1;
    rst = 1'b0;
    started = 1'b1;

    // Reset held with input activity
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0];
      in_data = 8'hEE;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 8'h00);
      chk("rst_occ", int'(occupancy), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      tick();
    end
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("lat_c3_valid", int'(out_valid), 0);
    tick();
    chk("lat_c4_valid", int'(out_valid), 1);
    chk("lat_c4_data", int'(out_data), 8'hA5);
    drain();

    // Streaming
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1;
      in_data = 8'(k);
      #1;
      chk("stream_in_ready", int'(in_ready), 1);
      if (k >= 5) begin
        chk("stream_out_data", int'(out_data), k - 4);
        chk("stream_occ", int'(occupancy), 4);
      end
      tick();
    end
    drain();

    // Backpressure and collapse
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h11 + j);
      #1;
      chk("bp_in_ready", int'(in_ready), (j < 4) ? 1 : 0);
      tick();
    end
    chk("bp_occ", int'(occupancy), 4);
    chk("bp_out_data", int'(out_data), 8'h11);
    out_ready = 1'b1;
    in_data = 8'h15;
    for (int t = 0; t < 5; t++) begin
      #1;
      chk("bp_rel_in_ready", int'(in_ready), 1);
      chk("bp_rel_out_data", int'(out_data), 8'h11 + t);
      chk("bp_rel_occ", int'(occupancy), 4);
      tick();
    end
    drain();

    // Bubble fill
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h21;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("bub_out_valid", int'(out_valid), 1);
    chk("bub_out_data", int'(out_data), 8'h21);
    chk("bub_occ1", int'(occupancy), 1);
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h22 + j);
      #1;
      chk("bub_in_ready", int'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("bub_occ4", int'(occupancy), 4);
    chk("bub_full_ready", int'(in_ready), 0);

    // Flush with occupancy 3 and a concurrent offer
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fl_pre_occ", int'(occupancy), 3);
    in_valid = 1'b1;
    in_data = 8'h77;
    flush = 1'b1;
    #1;
    chk("fl_in_ready", int'(in_ready), 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ", int'(occupancy), 0);
    chk("fl_out_valid", int'(out_valid), 0);
    chk("fl_out_data_kept", int'(out_data), 8'h22);
    out_ready = 1'b1;
    repeat (5) tick();
    chk("fl_no_77", int'(out_valid), 0);

    // Async reset mid-operation
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h31 + j);
      tick();
    end
    in_valid = 1'b0;
    chk("ar_pre_occ", int'(occupancy), 4);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_occ", int'(occupancy), 0);
    chk("ar_out_valid", int'(out_valid), 0);
    chk("ar_out_data", int'(out_data), 8'h00);
    chk("ar_in_ready", int'(in_ready), 1);
    mpos.delete();
    mdat.delete();
    mlast = RST_VAL;
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h41;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("ar_resume_valid", int'(out_valid), 1);
    chk("ar_resume_data", int'(out_data), 8'h41);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
